int_ins_de_stage: RTL
=====================

INT_INS_DE_STAGE -- requirements
Module: int_ins_de_stage

Interface
REQ-001 The block SHALL have parameter RV64, default 0, meaning 0 = RV32I decode and 1 = RV64I decode; CPU_WIDTH = 32*(RV64+1).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with the ports listed below.
REQ-003 clk  input  1  single clock; all state is rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_vld  input  1  upstream instruction valid.
REQ-006 in_rdy  output  1  stage can accept an instruction.
REQ-007 in_ins  input  32  raw instruction word.
REQ-008 in_pc, in_rs1Dat, in_rs2Dat  input  CPU_WIDTH each  PC, rs1 operand, rs2 operand.
REQ-009 flush  input  1  synchronous pipeline kill.
REQ-010 out_vld  output  1  decoded beat valid; out_rdy  input  1  execute stage accepts.
REQ-011 out_pc, out_s1, out_s2, out_offset  output  CPU_WIDTH each  execution operands.
REQ-012 out_flags  output  RV64+1  bit0 = unsigned, bit1 = .W (bit1 only when RV64=1).
REQ-013 out_op  output  18  one-hot-style enables with this bit order: 0 addEn, 1 subEn, 2 andEn, 3 orEn, 4 xorEn, 5 sltEn, 6 sftLeft, 7 sftRight, 8 sftA, 9 addSubIns, 10 bjEn, 11 branch, 12 beq, 13 bne, 14 blt, 15 bge, 16 jump, 17 memEn.
REQ-014 out_linkOffset  output  2  link increment code; out_rdIdx  output  5  destination; out_rdWen  output  1  destination write; out_illegal  output  1  illegal encoding.

Function
REQ-015 The stage SHALL be a single-entry registered stage with latency 1: a beat accepted on edge N appears on out_* after edge N.
REQ-016 in_rdy SHALL equal (!out_vld | out_rdy), driven combinationally; an accept occurs when in_vld & in_rdy.
REQ-017 While out_vld & !out_rdy, all out_* SHALL hold stable; an accept together with out_rdy SHALL replace the beat with no bubble.
REQ-018 flush SHALL clear out_vld on the next edge, override a simultaneous accept (that beat is dropped), and force in_rdy=1.
REQ-019 Decode: OP/OP-IMM SHALL set s1=rs1Dat and s2=rs2Dat or the sign-extended I-imm; ADD/ADDI SHALL set addEn; SUB SHALL set subEn; AND/OR/XOR SHALL set the matching enable; SLT* SHALL set subEn+sltEn; SLL SHALL set sftLeft; SRL SHALL set sftRight; SRA SHALL set sftRight+sftA.
REQ-020 addSubIns SHALL be set for ADD, ADDI, SUB, LUI, AUIPC, JAL and JALR only.
REQ-021 LUI SHALL set s1=0 and s2=U-imm with addEn; AUIPC SHALL set s1=pc and s2=U-imm with addEn.
REQ-022 BRANCH SHALL set s1/s2 to rs1Dat/rs2Dat, offset=B-imm, bjEn+branch+subEn, and beq/bne/blt/bge from funct3, with the unsigned variants using the same bit plus flags[0]=1.
REQ-023 JAL SHALL set offset=J-imm; JALR SHALL set s1=rs1Dat and offset=I-imm; both SHALL set bjEn+jump+addEn, linkOffset=2'b10 (+4), and s2=4.
REQ-024 LOAD/STORE SHALL set s1=rs1Dat, s2=I-imm or S-imm, and addEn+memEn.
REQ-025 flags[0] SHALL be 1 for SLTU, SLTIU, BLTU and BGEU; with RV64=1, OP-32/OP-IMM-32 SHALL decode as above with flags[1]=1.
REQ-026 All immediates SHALL be sign-extended to CPU_WIDTH except U-imm on RV32, which fills the width.
REQ-027 out_pc SHALL always carry in_pc.
REQ-028 out_rdWen SHALL be 0 for BRANCH, STORE, rd==0, and illegal encodings; otherwise 1.
REQ-029 An unrecognised opcode SHALL produce out_op=0 and out_rdWen=0.

Reset
REQ-030 rst_n low SHALL immediately clear out_vld and all out_* data/op registers to 0, regardless of clk.
REQ-031 in_rdy SHALL be 1 during reset, and the first accept SHALL occur on the first edge after rst_n rises.

Configuration
REQ-032 With macro INT_DE_ILLEGAL_CHK_EN defined, the stage SHALL flag out_illegal=1 and force out_op=0 and rdWen=0 for: unknown opcode, non-zero funct7 other than 0100000 on SUB/SRA/SRAI, shamt[5]=1 when RV64=0, and *W opcodes when RV64=0.
REQ-033 Without INT_DE_ILLEGAL_CHK_EN, out_illegal SHALL be tied 0, only funct7[5] SHALL be inspected, and only REQ-029 applies.

Verification
REQ-034 in_ins=0xFFD08293 (ADDI x5,x1,-3), rs1Dat=10 -> next cycle: out_vld=1, addEn=1, addSubIns=1, s1=10, s2=0xFFFFFFFD, rdIdx=5, rdWen=1.
REQ-035 in_ins=0x0020E463 (BLTU x1,x2,+8) -> out_op bits branch, bjEn, blt and subEn set, flags[0]=1, offset=8, rdWen=0.
REQ-036 out_rdy=0 for 3 cycles with a second beat pending -> in_rdy=0 and outputs held; the second beat appears the cycle after out_rdy=1.
REQ-037 flush with out_vld=1, out_rdy=0 and in_vld=1 -> out_vld=0 next cycle and the incoming beat never appears.
REQ-038 in_ins=0xFFFFFFFF -> with the macro, out_illegal=1, out_op=0, rdWen=0; without the macro, out_illegal=0 and out_op=0.
REQ-039 rst_n dropped mid-stall -> out_vld=0 and outputs=0 before the next clk edge.

Source files
------------

// File: rtl/int_ins_de_stage.sv
`default_nettype none
// ============================================================================
//  Module   : int_ins_de_stage
//  Brief    : RV32I/RV64I integer decode stage, single-entry valid/ready
//             register with flush. Macro INT_DE_ILLEGAL_CHK_EN enables
//             illegal-encoding detection.
//  Revision : 1.0
// ============================================================================
module int_ins_de_stage #(
   parameter int RV64 = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_vld,
   output logic                        in_rdy,
   input  logic [31:0]                 in_ins,
   input  logic [32*(RV64+1)-1:0]      in_pc,
   input  logic [32*(RV64+1)-1:0]      in_rs1Dat,
   input  logic [32*(RV64+1)-1:0]      in_rs2Dat,
   input  logic                        flush,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [32*(RV64+1)-1:0]      out_pc,
   output logic [32*(RV64+1)-1:0]      out_s1,
   output logic [32*(RV64+1)-1:0]      out_s2,
   output logic [32*(RV64+1)-1:0]      out_offset,
   output logic [RV64:0]               out_flags,
   output logic [17:0]                 out_op,
   output logic [1:0]                  out_linkOffset,
   output logic [4:0]                  out_rdIdx,
   output logic                        out_rdWen,
   output logic                        out_illegal
);

   localparam int CPU_WIDTH = 32 * (RV64 + 1);

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;

   localparam int OP_ADD = 0,  OP_SUB = 1,  OP_AND = 2,  OP_OR  = 3,  OP_XOR = 4;
   localparam int OP_SLT = 5,  OP_SL  = 6,  OP_SR  = 7,  OP_SA  = 8,  OP_ASI = 9;
   localparam int OP_BJ  = 10, OP_BR  = 11, OP_BEQ = 12, OP_BNE = 13, OP_BLT = 14;
   localparam int OP_BGE = 15, OP_JMP = 16, OP_MEM = 17;

   logic [6:0]           wOpc;
   logic [2:0]           wF3;
   logic                 wAlt;
   logic                 wIsOpReg;
   logic                 wIsOpImm;
   logic                 wIsWord;
   logic [CPU_WIDTH-1:0] wImmI, wImmS, wImmB, wImmJ, wImmU;
   logic [17:0]          wOp;
   logic [CPU_WIDTH-1:0] wS1, wS2, wOffset;
   logic [RV64:0]        wFlags;
   logic [1:0]           wLink;
   logic                 wKnown;
   logic                 wNoRd;
   logic                 wIllegal;
   logic                 wRdWen;
   logic                 wAccept;

   assign wOpc = in_ins[6:0];
   assign wF3  = in_ins[14:12];
   assign wAlt = in_ins[30];

   // Word-sized opcodes exist only in the RV64 decoder.
   assign wIsWord  = (RV64 != 0) && (wOpc == OPC_OP32 || wOpc == OPC_OPIMM32);
   assign wIsOpReg = (wOpc == OPC_OP)    || ((RV64 != 0) && wOpc == OPC_OP32);
   assign wIsOpImm = (wOpc == OPC_OPIMM) || ((RV64 != 0) && wOpc == OPC_OPIMM32);

   assign wImmI = {{(CPU_WIDTH-12){in_ins[31]}}, in_ins[31:20]};
   assign wImmS = {{(CPU_WIDTH-12){in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
   assign wImmB = {{(CPU_WIDTH-13){in_ins[31]}}, in_ins[31], in_ins[7],
                   in_ins[30:25], in_ins[11:8], 1'b0};
   assign wImmJ = {{(CPU_WIDTH-21){in_ins[31]}}, in_ins[31], in_ins[19:12],
                   in_ins[20], in_ins[30:21], 1'b0};

   generate
      if (RV64 != 0) begin : g_uimm64
         assign wImmU = {{(CPU_WIDTH-32){in_ins[31]}}, in_ins[31:12], 12'b0};
      end else begin : g_uimm32
         assign wImmU = {in_ins[31:12], 12'b0};
      end
   endgenerate

   always_comb begin
      wOp     = '0;
      wS1     = '0;
      wS2     = '0;
      wOffset = '0;
      wFlags  = '0;
      wLink   = 2'b00;
      wKnown  = 1'b0;
      wNoRd   = 1'b0;
      if (wIsOpReg || wIsOpImm) begin
         wKnown = 1'b1;
         wS1    = in_rs1Dat;
         wS2    = wIsOpReg ? in_rs2Dat : wImmI;
         if (wIsWord && (RV64 != 0)) wFlags[RV64] = 1'b1;
         case (wF3)
            3'b000: begin
               if (wIsOpReg && wAlt) wOp[OP_SUB] = 1'b1;
               else                  wOp[OP_ADD] = 1'b1;
               wOp[OP_ASI] = 1'b1;
            end
            3'b001: wOp[OP_SL] = 1'b1;
            3'b010: begin wOp[OP_SUB] = 1'b1; wOp[OP_SLT] = 1'b1; end
            3'b011: begin wOp[OP_SUB] = 1'b1; wOp[OP_SLT] = 1'b1; wFlags[0] = 1'b1; end
            3'b100: wOp[OP_XOR] = 1'b1;
            3'b101: begin wOp[OP_SR] = 1'b1; wOp[OP_SA] = wAlt; end
            3'b110: wOp[OP_OR] = 1'b1;
            default: wOp[OP_AND] = 1'b1;
         endcase
      end else begin
         case (wOpc)
            OPC_LUI, OPC_AUIPC: begin
               wKnown      = 1'b1;
               wS1         = (wOpc == OPC_AUIPC) ? in_pc : '0;
               wS2         = wImmU;
               wOp[OP_ADD] = 1'b1;
               wOp[OP_ASI] = 1'b1;
            end
            OPC_BRANCH: begin
               wKnown      = 1'b1;
               wNoRd       = 1'b1;
               wS1         = in_rs1Dat;
               wS2         = in_rs2Dat;
               wOffset     = wImmB;
               wOp[OP_BJ]  = 1'b1;
               wOp[OP_BR]  = 1'b1;
               wOp[OP_SUB] = 1'b1;
               wOp[OP_BEQ] = (wF3 == 3'b000);
               wOp[OP_BNE] = (wF3 == 3'b001);
               wOp[OP_BLT] = wF3[2] & ~wF3[0];
               wOp[OP_BGE] = wF3[2] &  wF3[0];
               wFlags[0]   = wF3[2] &  wF3[1];
            end
            OPC_JAL, OPC_JALR: begin
               wKnown      = 1'b1;
               wS1         = (wOpc == OPC_JALR) ? in_rs1Dat : in_pc;
               wS2         = CPU_WIDTH'(4);
               wOffset     = (wOpc == OPC_JALR) ? wImmI : wImmJ;
               wLink       = 2'b10;
               wOp[OP_BJ]  = 1'b1;
               wOp[OP_JMP] = 1'b1;
               wOp[OP_ADD] = 1'b1;
               wOp[OP_ASI] = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
               wKnown      = 1'b1;
               wNoRd       = (wOpc == OPC_STORE);
               wS1         = in_rs1Dat;
               wS2         = (wOpc == OPC_STORE) ? wImmS : wImmI;
               wOp[OP_ADD] = 1'b1;
               wOp[OP_MEM] = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef INT_DE_ILLEGAL_CHK_EN
   logic [6:0] wF7;
   logic [6:0] wImmF7;
   logic       wF7Bad;
   logic       wShamtBad;
   logic       wWordBad;

   assign wF7 = in_ins[31:25];
   // RV64 OP-IMM shifts carry shamt[5] in bit 25, so it is not part of funct7.
   assign wImmF7 = ((RV64 != 0) && wOpc == OPC_OPIMM) ? {in_ins[31:26], 1'b0} : in_ins[31:25];

   always_comb begin
      wF7Bad = 1'b0;
      if (wIsOpReg)
         wF7Bad = (wF7 != 7'd0) &&
                  !((wF7 == 7'b0100000) && (wF3 == 3'b000 || wF3 == 3'b101));
      else if (wIsOpImm && wF3 == 3'b001)
         wF7Bad = (wImmF7 != 7'd0);
      else if (wIsOpImm && wF3 == 3'b101)
         wF7Bad = (wImmF7 != 7'd0) && (wImmF7 != 7'b0100000);
   end

   assign wShamtBad = (RV64 == 0) && (wOpc == OPC_OPIMM) && (wF3[1:0] == 2'b01) && in_ins[25];
   assign wWordBad  = (RV64 == 0) && (wOpc == OPC_OP32 || wOpc == OPC_OPIMM32);
   assign wIllegal  = !wKnown || wF7Bad || wShamtBad || wWordBad;
`else
   assign wIllegal = 1'b0;
`endif

   assign wRdWen  = wKnown && !wNoRd && (in_ins[11:7] != 5'd0) && !wIllegal;
   assign in_rdy  = !out_vld || out_rdy || flush;
   assign wAccept = in_vld && in_rdy && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld        <= 1'b0;
         out_pc         <= '0;
         out_s1         <= '0;
         out_s2         <= '0;
         out_offset     <= '0;
         out_flags      <= '0;
         out_op         <= '0;
         out_linkOffset <= 2'b00;
         out_rdIdx      <= 5'd0;
         out_rdWen      <= 1'b0;
         out_illegal    <= 1'b0;
      end else begin
         if (flush)        out_vld <= 1'b0;
         else if (wAccept) out_vld <= 1'b1;
         else if (out_rdy) out_vld <= 1'b0;

         if (wAccept) begin
            out_pc         <= in_pc;
            out_s1         <= wS1;
            out_s2         <= wS2;
            out_offset     <= wOffset;
            out_flags      <= wFlags;
            out_op         <= wIllegal ? 18'd0 : wOp;
            out_linkOffset <= wLink;
            out_rdIdx      <= in_ins[11:7];
            out_rdWen      <= wRdWen;
            out_illegal    <= wIllegal;
         end
      end
   end

endmodule
`default_nettype wire
